// File: rtl/imem_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Packs a little-endian valid/ready byte stream into 32-bit words,
//            writes them to consecutive imem addresses and holds the CPU in
//            reset until the image is complete.
//            Optional trailing-checksum byte: IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] c_max_words = MAX_WORDS[ADDR_WIDTH:0];

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK = 3'd3,
`endif
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t                r_state;
    logic [1:0]            r_idx;
    logic [ADDR_WIDTH-1:0] r_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            r_sum;
    logic [7:0]            w_sum_next;
    assign w_sum_next = r_sum + s_data;
`endif

    logic w_count_ok;
    logic w_accept;
    logic w_last_word;

    assign w_count_ok  = (word_count != '0) && (word_count <= c_max_words);
    assign w_accept    = s_valid && s_ready;
    assign w_last_word = (imem_addr == r_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_last     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        done      <= 1'b0;
                        cpu_reset <= 1'b1;
                        if (w_count_ok) begin
                            r_state   <= RECV;
                            busy      <= 1'b1;
                            s_ready   <= 1'b1;
                            error     <= 1'b0;
                            imem_addr <= '0;
                            r_idx     <= '0;
                            r_last    <= ADDR_WIDTH'(word_count - 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_sum     <= '0;
`endif
                        end else begin
                            r_state <= ERR;
                            error   <= 1'b1;
                        end
                    end
                end

                RECV: begin
                    if (w_accept) begin
                        imem_wdata[{r_idx, 3'b000} +: 8] <= s_data;
                        r_idx <= r_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum <= w_sum_next;
`endif
                        if (r_idx == 2'd3) begin
                            r_state <= WRITE;
                            s_ready <= 1'b0;
                            imem_we <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    // Address is held on the last word so it never passes word_count-1
                    if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state <= CHECK;
                        s_ready <= 1'b1;
`else
                        r_state   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
`endif
                    end else begin
                        imem_addr <= imem_addr + 1'b1;
                        r_state   <= RECV;
                        s_ready   <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (w_accept) begin
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        if (w_sum_next == 8'd0) begin
                            r_state   <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            r_state <= ERR;
                            error   <= 1'b1;
                        end
                    end
                end
`endif

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Self-checking bench: table of load scenarios with randomized
//            images/handshakes, plus reset-mid-load and busy-start sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int AW   = 8;
    localparam int MAXW = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit c_ck = 1'b1;
`else
    localparam bit c_ck = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          start      = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          s_valid    = 1'b0;
    logic [7:0]    s_data     = '0;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;

    imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    logic [31:0] exp_words [0:MAXW-1];

    typedef struct {
        int count;
        bit rnd;
        bit fixed;
        bit bad_tail;
        bit exp_done;
        bit exp_err;
        int exp_cycles;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"},    32'(s_ready),   0);
        chk({tag, "_imem_we"},    32'(imem_we),   0);
        chk({tag, "_imem_addr"},  32'(imem_addr), 0);
        chk({tag, "_imem_wdata"}, imem_wdata,     0);
        chk({tag, "_cpu_reset"},  32'(cpu_reset), 1);
        chk({tag, "_busy"},       32'(busy),      0);
        chk({tag, "_done"},       32'(done),      0);
        chk({tag, "_error"},      32'(error),     0);
    endtask

    // Expected outcome from the loader's rules: valid count, checksum verdict, 5 cycles/word
    function automatic vec_t mk(input int count, input bit rnd, input bit fixed, input bit bad);
        vec_t v;
        bit   ok;
        ok           = (count >= 1) && (count <= MAXW);
        v.count      = count;
        v.rnd        = rnd;
        v.fixed      = fixed;
        v.bad_tail   = bad;
        v.exp_done   = ok && !(c_ck && bad);
        v.exp_err    = !v.exp_done;
        v.exp_cycles = 5 * count + 1 + (c_ck ? 1 : 0);
        return v;
    endfunction

    // Every write must land at the next address with the next image word
    always @(negedge clk) begin
        if (reset && imem_we) begin
            chk("write_addr",      32'(imem_addr), 32'(wr_cnt));
            chk("write_data",      imem_wdata,     exp_words[wr_cnt % MAXW]);
            chk("write_ready_low", 32'(s_ready),   0);
            wr_cnt++;
        end
    end

    task automatic run_vec(input vec_t v);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        logic [7:0] b8;
        int         bi;
        int         cyc;
        int         budget;
        bit         vv;
        bit         ok;
        ok     = (v.count >= 1) && (v.count <= MAXW);
        wr_cnt = 0;
        sum    = '0;
        if (ok) begin
            for (int i = 0; i < v.count; i++) exp_words[i] = $urandom;
            if (v.fixed) begin
                exp_words[0] = 32'h00A00093;
                if (v.count > 8) exp_words[8] = 32'h00208463;
            end
            for (int i = 0; i < v.count; i++) begin
                for (int b = 0; b < 4; b++) begin
                    b8 = exp_words[i][8*b +: 8];
                    bytes.push_back(b8);
                    sum = sum + b8;
                end
            end
            if (c_ck) bytes.push_back(v.bad_tail ? 8'(8'd1 - sum) : 8'(8'd0 - sum));
        end
        @(negedge clk);
        start      = 1'b1;
        word_count = v.count[AW:0];
        @(negedge clk);
        start = 1'b0;
        if (!ok) begin
            chk("badcount_error",     32'(error),     1);
            chk("badcount_busy",      32'(busy),      0);
            chk("badcount_cpu_reset", 32'(cpu_reset), 1);
            chk("badcount_done",      32'(done),      0);
            repeat (3) @(negedge clk);
            chk("badcount_no_write",  32'(wr_cnt),    0);
            chk("badcount_err_hold",  32'(error),     1);
            return;
        end
        chk("start_busy",      32'(busy),      1);
        chk("start_ready",     32'(s_ready),   1);
        chk("start_done_clr",  32'(done),      0);
        chk("start_cpu_reset", 32'(cpu_reset), 1);
        cyc    = 1;
        bi     = 0;
        budget = 20 * v.count + 50;
        while (!done && !error && cyc < budget) begin
            vv = v.rnd ? bit'($urandom_range(0, 1)) : 1'b1;
            if (bi >= bytes.size()) vv = 1'b0;
            s_valid = vv;
            s_data  = vv ? bytes[bi] : 8'($urandom);
            if (vv && s_ready) bi++;
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        chk("end_done",      32'(done),      32'(v.exp_done));
        chk("end_error",     32'(error),     32'(v.exp_err));
        chk("end_cpu_reset", 32'(cpu_reset), 32'(!v.exp_done));
        chk("end_busy",      32'(busy),      0);
        chk("end_writes",    32'(wr_cnt),    32'(v.count));
        chk("end_consumed",  32'(bi),        32'(bytes.size()));
        if (!v.rnd) chk("end_latency", 32'(cyc), 32'(v.exp_cycles));
    endtask

    task automatic reset_mid_load();
        int bi;
        int cyc;
        wr_cnt = 0;
        for (int i = 0; i < 5; i++) exp_words[i] = $urandom;
        @(negedge clk);
        start      = 1'b1;
        word_count = 9'd5;
        @(negedge clk);
        start = 1'b0;
        bi    = 0;
        cyc   = 0;
        // Feed three words plus two bytes; an invalid start mid-load must be ignored
        while (bi < 14 && cyc < 200) begin
            start      = (cyc == 3);
            word_count = '0;
            s_valid    = 1'b1;
            s_data     = exp_words[bi / 4][8*(bi % 4) +: 8];
            if (s_ready) bi++;
            @(negedge clk);
            cyc++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        chk("busy_start_ignored", 32'(error),  0);
        chk("busy_still_loading", 32'(busy),   1);
        chk("midload_writes",     32'(wr_cnt), 3);
        #2 reset = 1'b0;
        #1 chk_reset_vals("async_reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        vec_t vecs[10];
        vecs[0] = mk(1,        1'b0, 1'b1, 1'b0);
        vecs[1] = mk(0,        1'b0, 1'b0, 1'b0);
        vecs[2] = mk(2,        1'b0, 1'b0, 1'b0);
        vecs[3] = mk(MAXW + 1, 1'b0, 1'b0, 1'b0);
        vecs[4] = mk(9,        1'b1, 1'b1, 1'b0);
        vecs[5] = mk(1,        1'b0, 1'b1, 1'b1);
        vecs[6] = mk(3,        1'b1, 1'b0, 1'b0);
        vecs[7] = mk(4,        1'b0, 1'b0, 1'b1);
        vecs[8] = mk(MAXW,     1'b1, 1'b0, 1'b0);
        vecs[9] = mk(0,        1'b0, 1'b0, 1'b0);

        #12 chk_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        reset_mid_load();
        run_vec(mk(2, 1'b1, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
